// File: rtl/uart_tx_core_pkg.sv
// Shared types and helpers for the 8N1 UART transmitter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int uart_div(int clk_hz, int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Byte-stream valid/ready handshake into the UART transmitter.
interface uart_tx_core_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead byte FIFO with registered full/empty flags.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop;

  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  // Next pointer values, shared by the pointer and flag registers.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    wr_ptr_nxt = wr_ptr + (AW + 1)'(push);
    rd_ptr_nxt = rd_ptr + (AW + 1)'(pop);
  end

  // Pointers and registered full/empty flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised LSB first, frames back-to-back.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUDRATE    = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_core_if.slave                 tx,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV   = uart_div(CLK_FREQ_HZ, BAUDRATE);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "uart_tx_core: divisor %0d is below 2", DIV);
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "uart_tx_core: FIFO_DEPTH %0d is not a power of two >= 2", FIFO_DEPTH);
  end

  uart_tx_state_e         state;
  logic [CNT_W-1:0]       baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift;
  logic [UART_DATA_W-1:0] fifo_head;
  logic                   fifo_full, fifo_empty, fifo_rd;
  logic                   baud_last;

  assign baud_last   = (baud_cnt == BAUD_LAST);
  // Pop from IDLE, or at the last clock of a stop bit so the next start bit follows at once.
  assign fifo_rd     = ~fifo_empty & ((state == IDLE) | ((state == STOP) & baud_last));
  assign tx.tx_ready = ~fifo_full;
  assign busy        = (state != IDLE) | (fifo_level != '0);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx.tx_valid),
    .wr_data (tx.tx_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Frame sequencer: state, baud counter, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      baud_cnt <= ((state == IDLE) || baud_last) ? '0 : baud_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (fifo_rd) begin
            shift <= fifo_head;
            state <= START;
          end
        end
        START: begin
          if (baud_last) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_last) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (baud_last) begin
            if (fifo_rd) begin
              shift <= fifo_head;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered line driver, one clock behind the sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd <= 1'b1;
    end else begin
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shift[0];
        default: txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core with a serial-line receiver model and byte scoreboard.
module tb_uart_tx_core;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;
  localparam int FRAME  = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_level;

  uart_tx_core_if ifc ();

  uart_tx_core #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUDRATE    (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (ifc),
    .txd        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int         cyc       = 0;
  int         rst_count = 0;
  int         checks    = 0;
  int         errors    = 0;
  logic [7:0] sb_q[$];
  int         start_q[$];

  // Edge counter and a record of every reset edge for the receiver model.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_count <= rst_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte with tx_valid held until accepted; returns the accepting edge number.
  task automatic push(input logic [7:0] b, output int acc);
    bit ready_now;
    bit accepted;
    accepted = 1'b0;
    acc      = -1;
    @(negedge clk);
    ifc.tx_data  = b;
    ifc.tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      ready_now = ifc.tx_ready;
      acc       = cyc + 1;
      @(posedge clk);
      if (ready_now) begin
        accepted = 1'b1;
        sb_q.push_back(b);
        break;
      end
      @(negedge clk);
    end
    check("push_accept", accepted, 1);
  endtask

  // Wait until the transmitter is idle and every scoreboard byte has been received.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", done, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic rx_wait(input int n, input int rc, inout bit ok);
    for (int k = 0; k < n && ok; k++) begin
      @(negedge clk);
      if (rst_count != rc) ok = 1'b0;
    end
  endtask

  // Serial-line receiver: samples each bit at its centre and checks against the scoreboard.
  initial begin : rx_model
    int         rc;
    bit         ok;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        rc = rst_count;
        ok = 1'b1;
        b  = '0;
        start_q.push_back(cyc);
        rx_wait(DIV / 2 - 1, rc, ok);
        if (ok) check("rx_start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          rx_wait(DIV, rc, ok);
          b[i] = txd;
        end
        rx_wait(DIV, rc, ok);
        if (ok) begin
          check("rx_stop_bit", txd, 1);
          check("rx_sb_has_byte", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) check("rx_byte", b, sb_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acc;
    int a0;
    logic [7:0] burst [4];
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h0F;
    ifc.tx_data  = '0;
    ifc.tx_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tx_ready", ifc.tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single byte latency and busy release.
    push(8'hA5, acc);
    @(negedge clk);
    ifc.tx_valid = 1'b0;
    check("t1_level_after_accept", fifo_level, 1);
    check("t1_busy_after_accept", busy, 1);
    @(negedge clk);
    check("t1_txd_high_n1", txd, 1);
    @(negedge clk);
    check("t1_txd_low_n2", txd, 0);
    while (cyc < acc + FRAME) @(negedge clk);
    check("t1_busy_at_n100", busy, 1);
    @(negedge clk);
    check("t1_busy_low_n101", busy, 0);
    drain();

    // 2: back-to-back burst, frames exactly 100 clocks apart.
    start_q.delete();
    push(burst[0], a0);
    for (int i = 1; i < 4; i++) push(burst[i], acc);
    @(negedge clk);
    ifc.tx_valid = 1'b0;
    drain();
    check("t2_frame_count", start_q.size(), 4);
    if (start_q.size() == 4) begin
      check("t2_first_start", start_q[0], a0 + 2);
      for (int i = 1; i < 4; i++) check("t2_frame_gap", start_q[i] - start_q[i-1], FRAME);
    end

    // 3: fill to capacity; 6: pulses while full; 4: push at the pop edge.
    start_q.delete();
    push(8'h11, a0);
    push(8'h22, acc);
    push(8'h33, acc);
    push(8'h44, acc);
    push(8'h55, acc);
    @(negedge clk);
    check("t3_ready_low_full", ifc.tx_ready, 0);
    check("t3_level_full", fifo_level, 4);
    for (int i = 0; i < 6; i++) begin
      ifc.tx_data  = 8'($urandom);
      ifc.tx_valid = i[0];
      @(negedge clk);
      check("t6_level_unchanged", fifo_level, 4);
      check("t6_ready_low", ifc.tx_ready, 0);
    end
    push(8'h66, acc);
    check("t4_accept_after_pop", acc, a0 + FRAME + 2);
    @(negedge clk);
    ifc.tx_valid = 1'b0;
    check("t4_level_refilled", fifo_level, 4);
    drain();
    check("t3_frame_count", start_q.size(), 6);

    // 5: reset during DATA bit 3 with two bytes queued.
    start_q.delete();
    push(8'h3C, a0);
    push(8'hDE, acc);
    push(8'hAD, acc);
    @(negedge clk);
    ifc.tx_valid = 1'b0;
    while (cyc < a0 + 45) @(negedge clk);
    check("t5_frame_in_flight", busy, 1);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("t5_txd_after_rst", txd, 1);
    check("t5_level_after_rst", fifo_level, 0);
    check("t5_busy_after_rst", busy, 0);
    check("t5_ready_after_rst", ifc.tx_ready, 1);
    start_q.delete();
    repeat (2 * FRAME) @(negedge clk);
    check("t5_no_resume", start_q.size(), 0);
    check("t5_txd_idle", txd, 1);
    push(8'h81, acc);
    @(negedge clk);
    ifc.tx_valid = 1'b0;
    drain();
    check("t5_post_rst_frames", start_q.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
